move_collector: RTL



---
 rtl/move_collector.sv | 121 ++++++++++++
 1 files changed

// File: rtl/move_collector.sv
// Drains the per-square move FIFOs after every square unit is done, unpacking
// each word into 19-bit moves on a valid/ready stream. Optional counter: MOVE_COUNT_EN.
module move_collector #(
  parameter int NUM_SQ = 64,
  parameter int IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_SQ-1:0]     sq_done,
  input  logic [NUM_SQ-1:0]     sq_empty,
  input  logic [NUM_SQ*160-1:0] sq_q,
  output logic [NUM_SQ-1:0]     sq_rden,
  output logic [18:0]           mv_data,
  output logic                  mv_valid,
  input  logic                  mv_ready,
  output logic                  busy,
  output logic                  pass_done,
  output logic [7:0]            mv_count
);

  localparam int WORD_W = 160;
  localparam int PAY_W  = 152;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITD, S_SCAN, S_READ, S_LATCH, S_UNPK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAY_W-1:0]   word_q, word_d;
  logic [2:0]         slot_q, slot_d;
  logic [18:0]        cur_slot;
  logic               slot_skip;

  assign cur_slot  = word_q[32'(slot_q) * 19 +: 19];
  assign slot_skip = cur_slot[18];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAITD;
          idx_d   = '0;
        end
      end
      S_WAITD: begin
        if (&sq_done) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!sq_empty[idx_q])    state_d = S_READ;
        else if (idx_q == LAST_IDX) state_d = S_DONE;
        else                     idx_d = idx_q + 1'b1;
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        // FIFO output is valid the cycle after the read strobe; pad byte dropped here
        word_d  = sq_q[32'(idx_q) * WORD_W +: PAY_W];
        slot_d  = 3'd7;
        state_d = S_UNPK;
      end
      S_UNPK: begin
        if (slot_skip || mv_ready) begin
          if (slot_q == 3'd0) state_d = S_SCAN;
          else                slot_d  = slot_q - 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mv_valid  = (state_q == S_UNPK) && !slot_skip;
    mv_data   = mv_valid ? cur_slot : '0;
    sq_rden   = (state_q == S_READ) ? ({{(NUM_SQ-1){1'b0}}, 1'b1} << idx_q) : '0;
    busy      = (state_q != S_IDLE);
    pass_done = (state_q == S_DONE);
  end

`ifdef MOVE_COUNT_EN
  logic [7:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (state_q == S_IDLE && start)
      count_d = '0;
    else if (mv_valid && mv_ready && count_q != 8'hFF)
      count_d = count_q + 8'd1;
  end

  assign mv_count = count_q;
`else
  assign mv_count = 8'd0;
`endif

endmodule
